// File: rtl/letter_dropper.sv
// Falling-byte game state for the framebuffer renderer: three slots spawn LFSR
// bytes at row 0, drop one row per fall tick, and clear on a matching guess.
module letter_dropper #(
  parameter int         TICK_DIV    = 2_500_000,
  parameter int         SPAWN_TICKS = 8,
  parameter int         FLOOR       = 22,
  parameter logic [7:0] SEED        = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] guess,
  input  logic       guess_valid,
  output logic [7:0] letter1,
  output logic [7:0] letter2,
  output logic [7:0] letter3,
  output logic [4:0] ypos1,
  output logic [4:0] ypos2,
  output logic [4:0] ypos3,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_TICKS - 1);
  localparam logic [4:0]    FLOOR_ROW  = 5'(FLOOR);
  localparam logic [7:0]    SEED_NZ    = (SEED == 8'h00) ? 8'h01 : SEED;

  // Galois form of x^8+x^6+x^5+x^4+1, shifting right.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [1:0] sat_sub2(input logic [1:0] v, input logic [1:0] n);
    return (n >= v) ? 2'd0 : v - n;
  endfunction

  logic [2:0]    r_falling;
  logic [7:0]    r_letter [3];
  logic [4:0]    r_ypos   [3];
  logic [7:0]    r_score;
  logic [1:0]    r_lives;
  logic          r_game_over;
  logic [TW-1:0] r_tick_cnt;
  logic [SW-1:0] r_spawn_cnt;
  logic [7:0]    r_lfsr;

  logic [2:0]    w_falling_nxt;
  logic [7:0]    w_letter_nxt [3];
  logic [4:0]    w_ypos_nxt   [3];
  logic [7:0]    w_score_nxt;
  logic [1:0]    w_lives_nxt;
  logic          w_game_over_nxt;
  logic [TW-1:0] w_tick_cnt_nxt;
  logic [SW-1:0] w_spawn_cnt_nxt;
  logic [7:0]    w_lfsr_nxt;

  logic          w_tick;
  logic          w_spawn_try;
  logic          w_hit;
  logic [1:0]    w_hit_idx;
  logic [4:0]    w_best;
  logic [1:0]    w_misses;
  logic          w_placed;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_falling   <= '0;
      for (int i = 0; i < 3; i++) begin
        r_letter[i] <= 8'd0;
        r_ypos[i]   <= FLOOR_ROW;
      end
      r_score     <= 8'd0;
      r_lives     <= 2'd3;
      r_game_over <= 1'b0;
      r_tick_cnt  <= '0;
      r_spawn_cnt <= '0;
      r_lfsr      <= SEED_NZ;
    end else begin
      r_falling   <= w_falling_nxt;
      for (int i = 0; i < 3; i++) begin
        r_letter[i] <= w_letter_nxt[i];
        r_ypos[i]   <= w_ypos_nxt[i];
      end
      r_score     <= w_score_nxt;
      r_lives     <= w_lives_nxt;
      r_game_over <= w_game_over_nxt;
      r_tick_cnt  <= w_tick_cnt_nxt;
      r_spawn_cnt <= w_spawn_cnt_nxt;
      r_lfsr      <= w_lfsr_nxt;
    end
  end

  always_comb begin
    w_tick      = (r_tick_cnt == TICK_LAST);
    w_spawn_try = w_tick && (r_spawn_cnt == SPAWN_LAST);

    // Hit arbitration on pre-tick state: deepest match wins, lower index on ties.
    w_hit     = 1'b0;
    w_hit_idx = 2'd0;
    w_best    = 5'd0;
    for (int i = 0; i < 3; i++) begin
      if (guess_valid && r_falling[i] && (r_letter[i] == guess) &&
          (!w_hit || (r_ypos[i] > w_best))) begin
        w_hit     = 1'b1;
        w_hit_idx = 2'(i);
        w_best    = r_ypos[i];
      end
    end

    w_falling_nxt = r_falling;
    w_misses      = 2'd0;
    for (int i = 0; i < 3; i++) begin
      w_letter_nxt[i] = r_letter[i];
      w_ypos_nxt[i]   = r_ypos[i];
      if (w_hit && (w_hit_idx == 2'(i))) begin
        w_falling_nxt[i] = 1'b0;
        w_ypos_nxt[i]    = FLOOR_ROW;
      end else if (w_tick && r_falling[i]) begin
        if ((r_ypos[i] + 5'd1) == FLOOR_ROW) begin
          w_falling_nxt[i] = 1'b0;
          w_ypos_nxt[i]    = FLOOR_ROW;
          w_misses         = w_misses + 2'd1;
        end else begin
          w_ypos_nxt[i] = r_ypos[i] + 5'd1;
        end
      end
    end

    // Spawn looks at post-hit/post-miss occupancy so freed slots refill at once.
    w_placed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (w_spawn_try && !w_placed && !w_falling_nxt[i]) begin
        w_falling_nxt[i] = 1'b1;
        w_letter_nxt[i]  = r_lfsr;
        w_ypos_nxt[i]    = 5'd0;
        w_placed         = 1'b1;
      end
    end

    w_score_nxt     = w_hit ? sat_inc8(r_score) : r_score;
    w_lives_nxt     = sat_sub2(r_lives, w_misses);
    w_tick_cnt_nxt  = w_tick ? '0 : r_tick_cnt + TW'(1);
    w_spawn_cnt_nxt = r_spawn_cnt;
    if (w_tick) begin
      w_spawn_cnt_nxt = (r_spawn_cnt == SPAWN_LAST) ? '0 : r_spawn_cnt + SW'(1);
    end
    w_lfsr_nxt      = lfsr_step(r_lfsr);
    w_game_over_nxt = (r_lives == 2'd0);

    if (r_game_over) begin
      w_falling_nxt = r_falling;
      for (int i = 0; i < 3; i++) begin
        w_letter_nxt[i] = r_letter[i];
        w_ypos_nxt[i]   = r_ypos[i];
      end
      w_score_nxt     = r_score;
      w_lives_nxt     = r_lives;
      w_tick_cnt_nxt  = r_tick_cnt;
      w_spawn_cnt_nxt = r_spawn_cnt;
      w_lfsr_nxt      = r_lfsr;
      w_game_over_nxt = 1'b1;
    end
  end

  assign letter1   = r_letter[0];
  assign letter2   = r_letter[1];
  assign letter3   = r_letter[2];
  assign ypos1     = r_ypos[0];
  assign ypos2     = r_ypos[1];
  assign ypos3     = r_ypos[2];
  assign score     = r_score;
  assign lives     = r_lives;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_letter_dropper.sv
// Bench for letter_dropper: cycle scoreboard against a behavioural model plus
// a table of hit vectors and hand sequences for tie-break and game-over.
module tb_letter_dropper;

  localparam int         TD = 4;
  localparam int         ST = 1;
  localparam int         FL = 22;
  localparam logic [7:0] SD = 8'hA5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, reset_b;
  logic [7:0] guess, guess_b;
  logic       guess_valid, guess_valid_b;
  logic [7:0] l1, l2, l3, sc, l1b, l2b, l3b, scb;
  logic [4:0] y1, y2, y3, y1b, y2b, y3b;
  logic [1:0] lv, lvb;
  logic       go, gob;

  letter_dropper #(.TICK_DIV(TD), .SPAWN_TICKS(ST), .FLOOR(FL), .SEED(SD)) dut (
    .clock(clock), .reset(reset), .guess(guess), .guess_valid(guess_valid),
    .letter1(l1), .letter2(l2), .letter3(l3), .ypos1(y1), .ypos2(y2), .ypos3(y3),
    .score(sc), .lives(lv), .game_over(go));

  // Period equal to the LFSR period, so every spawn draws the same byte.
  letter_dropper #(.TICK_DIV(255), .SPAWN_TICKS(1), .FLOOR(FL), .SEED(SD)) dut_b (
    .clock(clock), .reset(reset_b), .guess(guess_b), .guess_valid(guess_valid_b),
    .letter1(l1b), .letter2(l2b), .letter3(l3b), .ypos1(y1b), .ypos2(y2b), .ypos3(y3b),
    .score(scb), .lives(lvb), .game_over(gob));

  typedef struct packed {
    logic [7:0] l1, l2, l3;
    logic [4:0] y1, y2, y3;
    logic [7:0] sc;
    logic [1:0] lv;
    logic       go;
  } obs_t;

  typedef struct {
    int slot;      // 0: guess a byte no slot holds
    int row;
    bit on_tick;
    int exp_score;
    int exp_lives;
    int exp_y;     // -1: not checked
  } hv_t;

  obs_t exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  bit         m_fall [3];
  logic [7:0] m_let  [3];
  int         m_y    [3];
  int         m_sc, m_lv, m_t, m_s;
  bit         m_go;
  logic [7:0] m_lfsr;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.l1 = m_let[0]; o.l2 = m_let[1]; o.l3 = m_let[2];
    o.y1 = 5'(m_y[0]); o.y2 = 5'(m_y[1]); o.y3 = 5'(m_y[2]);
    o.sc = 8'(m_sc); o.lv = 2'(m_lv); o.go = m_go;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.l1 = l1; o.l2 = l2; o.l3 = l3;
    o.y1 = y1; o.y2 = y2; o.y3 = y3;
    o.sc = sc; o.lv = lv; o.go = go;
    return o;
  endfunction

  function automatic int dut_y(input int s);
    case (s)
      1: return int'(y1);
      2: return int'(y2);
      default: return int'(y3);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_fall[i] = 1'b0; m_let[i] = 8'd0; m_y[i] = FL;
    end
    m_sc = 0; m_lv = 3; m_go = 1'b0; m_t = 0; m_s = 0; m_lfsr = SD;
  endtask

  task automatic model_step(input bit gv, input logic [7:0] g);
    int best, miss, lv_old;
    bit tk, placed;
    if (m_go) return;
    tk = (m_t == TD - 1);
    lv_old = m_lv;
    best = -1;
    for (int i = 0; i < 3; i++)
      if (gv && m_fall[i] && m_let[i] == g && (best < 0 || m_y[i] > m_y[best])) best = i;
    miss = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == best) begin
        m_fall[i] = 1'b0; m_y[i] = FL;
      end else if (tk && m_fall[i]) begin
        m_y[i] = m_y[i] + 1;
        if (m_y[i] == FL) begin m_fall[i] = 1'b0; miss++; end
      end
    end
    if (best >= 0 && m_sc < 255) m_sc++;
    m_lv = (m_lv > miss) ? m_lv - miss : 0;
    placed = 1'b0;
    if (tk && m_s == ST - 1)
      for (int i = 0; i < 3; i++)
        if (!placed && !m_fall[i]) begin
          m_fall[i] = 1'b1; m_let[i] = m_lfsr; m_y[i] = 0; placed = 1'b1;
        end
    if (tk) m_s = (m_s == ST - 1) ? 0 : m_s + 1;
    m_t = (m_t == TD - 1) ? 0 : m_t + 1;
    m_lfsr = lfsr_next(m_lfsr);
    m_go = (lv_old == 0);
  endtask

  task automatic check_obs(input string name);
    obs_t e, a;
    e = exp_q.pop_front();
    a = dut_obs();
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, required %h", name, $time, a, e);
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, required %0d", name, $time, act, req);
    end
  endtask

  task automatic cyc(input bit gv, input logic [7:0] g);
    guess_valid = gv;
    guess = g;
    model_step(gv, g);
    exp_q.push_back(model_obs());
    @(posedge clock); #1;
    check_obs("cycle");
    guess_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    guess_valid = 1'b0;
    model_reset();
    exp_q.push_back(model_obs());
    @(posedge clock); #1;
    check_obs("reset");
    reset = 1'b0;
  endtask

  hv_t tbl[4];

  initial begin
    logic [7:0] g, bv;
    bit found, clash;
    int cnt;

    tbl[0] = '{slot: 0, row: 0,  on_tick: 1'b0, exp_score: 0, exp_lives: 3, exp_y: -1};
    tbl[1] = '{slot: 2, row: 3,  on_tick: 1'b0, exp_score: 1, exp_lives: 3, exp_y: FL};
    tbl[2] = '{slot: 1, row: 21, on_tick: 1'b1, exp_score: 2, exp_lives: 3, exp_y: 0};
    tbl[3] = '{slot: 3, row: 21, on_tick: 1'b1, exp_score: 3, exp_lives: 3, exp_y: 0};

    reset = 1'b1; reset_b = 1'b1;
    guess = 8'd0; guess_b = 8'd0; guess_valid = 1'b0; guess_valid_b = 1'b0;
    @(posedge clock); #1;
    do_reset();
    chk("rst_ypos1", int'(y1), FL);
    chk("rst_lives", int'(lv), 3);
    chk("rst_score", int'(sc), 0);
    chk("rst_game_over", int'(go), 0);

    // First tick after reset spawns slot 1 with the LFSR three steps past A5.
    cyc(1'b0, 8'd0); cyc(1'b0, 8'd0); cyc(1'b0, 8'd0);
    chk("pre_spawn_ypos1", int'(y1), FL);
    cyc(1'b0, 8'd0);
    chk("spawn_letter1", int'(l1), 8'h82);
    chk("spawn_ypos1", int'(y1), 0);

    foreach (tbl[k]) begin
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
        g = 8'd0;
        if (tbl[k].slot == 0) begin
          for (int v = 0; v < 256 && !found; v++) begin
            bv = 8'(v);
            clash = 1'b0;
            for (int i = 0; i < 3; i++) if (m_fall[i] && m_let[i] == bv) clash = 1'b1;
            if (!clash) begin g = bv; found = 1'b1; end
          end
        end else if (m_fall[tbl[k].slot-1] && m_y[tbl[k].slot-1] == tbl[k].row &&
                     ((m_t == TD - 1) == tbl[k].on_tick)) begin
          g = m_let[tbl[k].slot-1];
          found = 1'b1;
        end
        cyc(found, g);
      end
      chk($sformatf("vec%0d_trigger", k), int'(found), 1);
      chk($sformatf("vec%0d_score", k), int'(sc), tbl[k].exp_score);
      chk($sformatf("vec%0d_lives", k), int'(lv), tbl[k].exp_lives);
      if (tbl[k].exp_y >= 0)
        chk($sformatf("vec%0d_ypos", k), dut_y(tbl[k].slot), tbl[k].exp_y);
    end

    // Let the remaining slots miss until the game ends.
    cnt = 0;
    while (!m_go && cnt < 600) begin cyc(1'b0, 8'd0); cnt++; end
    chk("reach_game_over", int'(m_go), 1);
    chk("go_flag", int'(go), 1);
    chk("go_lives", int'(lv), 0);
    chk("go_score", int'(sc), 3);

    for (int c = 0; c < 40; c++) cyc(c[0], m_let[c % 3]);
    chk("frozen_flag", int'(go), 1);
    chk("frozen_lives", int'(lv), 0);
    chk("frozen_score", int'(sc), 3);

    do_reset();
    chk("rerst_lives", int'(lv), 3);
    chk("rerst_game_over", int'(go), 0);
    chk("rerst_score", int'(sc), 0);

    // Tie-break: three slots with identical bytes at rows 2, 1 and 0.
    bv = SD;
    for (int i = 0; i < 254; i++) bv = lfsr_next(bv);
    reset_b = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(posedge clock); #1;
      if (y3b == 5'd0) found = 1'b1;
    end
    chk("tie_spawned", int'(found), 1);
    chk("tie_letter1", int'(l1b), int'(bv));
    chk("tie_letter2", int'(l2b), int'(bv));
    chk("tie_letter3", int'(l3b), int'(bv));
    chk("tie_ypos1_pre", int'(y1b), 2);
    chk("tie_ypos2_pre", int'(y2b), 1);
    guess_b = bv; guess_valid_b = 1'b1;
    @(posedge clock); #1;
    guess_valid_b = 1'b0;
    chk("tie_ypos1", int'(y1b), FL);
    chk("tie_ypos2", int'(y2b), 1);
    chk("tie_ypos3", int'(y3b), 0);
    chk("tie_score", int'(scb), 1);
    chk("tie_lives", int'(lvb), 3);
    chk("tie_game_over", int'(gob), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
